// File: rtl/pwm_io_pkg.sv
// Shared definitions for the PWM register interface: decoder FSM states
// and the register-map geometry (4 channels x 6 bytes).
package pwm_io_pkg;

  localparam int NUM_CHANNELS   = 4;
  localparam int CHANNEL_STRIDE = 6;
  localparam int REG_MAP_SIZE   = NUM_CHANNELS * CHANNEL_STRIDE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } dec_state_t;

endpackage : pwm_io_pkg

// File: rtl/addr_pointer_wrap.sv
// Register-address pointer: loaded from the address byte, then stepped
// after each write when auto-increment is enabled, wrapping at NumRegs-1.
module addr_pointer_wrap #(
  parameter int NumRegs = 24
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_load,
  input  logic [6:0] i_load_value,
  input  logic       i_load_inc_en,
  input  logic       i_advance,
  output logic [6:0] o_pointer
);

  localparam logic [6:0] LP_LAST = 7'(NumRegs - 1);

  logic [6:0] r_pointer;
  logic       r_inc_en;
  logic [6:0] w_pointer_next;

  // Next sequential address; anything at or beyond the last register wraps to 0
  always_comb begin
    w_pointer_next = r_pointer + 7'd1;
    if (r_pointer >= LP_LAST) begin
      w_pointer_next = '0;
    end
  end

  // Pointer and increment-mode registers; a load takes priority over advancing
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_pointer <= '0;
      r_inc_en  <= 1'b0;
    end else if (i_load) begin
      r_pointer <= i_load_value;
      r_inc_en  <= i_load_inc_en;
    end else if (i_advance && r_inc_en) begin
      r_pointer <= w_pointer_next;
    end
  end

  assign o_pointer = r_pointer;

endmodule : addr_pointer_wrap

// File: rtl/spi_frame_decoder.sv
// Turns a chip-select framed byte stream into register writes: the first
// byte of a frame is the address (bit 7 flips auto-increment), the rest are
// data bytes written one cycle after they arrive.
module spi_frame_decoder
  import pwm_io_pkg::*;
#(
  parameter int NumRegs        = REG_MAP_SIZE,
  parameter int AutoIncDefault = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       _CS,
  input  logic       RXValid,
  input  logic [7:0] RXData,
  output logic [7:0] AddressBus,
  output logic [7:0] WriteBus,
  output logic       _Write,
  output logic       FrameError,
  output logic       Busy
);

  localparam logic [7:0] LP_NUM_REGS = 8'(NumRegs);
  localparam logic       LP_AUTO_INC = (AutoIncDefault != 0);

  dec_state_t r_state;
  dec_state_t w_state_next;

  logic [7:0] r_address_bus;
  logic [7:0] r_write_bus;
  logic       r_write_n;
  logic       r_frame_error;

  logic       w_load;
  logic       w_load_inc_en;
  logic       w_write;
  logic       w_set_err;
  logic       w_clr_err;
  logic [6:0] w_pointer;

  addr_pointer_wrap #(
    .NumRegs(NumRegs)
  ) u_pointer (
    .i_clk        (CLK),
    .i_srst       (RST),
    .i_load       (w_load),
    .i_load_value (RXData[6:0]),
    .i_load_inc_en(w_load_inc_en),
    .i_advance    (w_write),
    .o_pointer    (w_pointer)
  );

  assign w_load_inc_en = LP_AUTO_INC ^ RXData[7];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle actions; a byte arriving as _CS rises is still
  // handled by the current state before the frame closes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_write      = 1'b0;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!_CS) begin
          w_state_next = ST_ADDR;
          w_clr_err    = 1'b1;
        end
      end
      ST_ADDR: begin
        if (RXValid) begin
          w_load = 1'b1;
          if ({1'b0, RXData[6:0]} < LP_NUM_REGS) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_DISCARD;
            w_set_err    = 1'b1;
          end
        end
        if (_CS) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (RXValid) begin
          w_write = 1'b1;
        end
        if (_CS) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (_CS) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Write bus registers: strobe for one cycle, hold address/data otherwise
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_address_bus <= 8'h00;
      r_write_bus   <= 8'h00;
      r_write_n     <= 1'b1;
    end else begin
      r_write_n <= ~w_write;
      if (w_write) begin
        r_address_bus <= {1'b0, w_pointer};
        r_write_bus   <= RXData;
      end
    end
  end

  // Sticky frame error, cleared when a new frame opens
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_error <= 1'b0;
    end else if (w_set_err) begin
      r_frame_error <= 1'b1;
    end else if (w_clr_err) begin
      r_frame_error <= 1'b0;
    end
  end

  assign AddressBus = r_address_bus;
  assign WriteBus   = r_write_bus;
  assign _Write     = r_write_n;
  assign FrameError = r_frame_error;
  assign Busy       = (r_state != ST_IDLE);

endmodule : spi_frame_decoder

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: frames are driven byte by byte and
// the write bus is checked 1 time unit after each rising edge.
module tb_spi_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] address_bus;
  logic [7:0] write_bus;
  logic       write_n;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_frame_decoder #(
    .NumRegs       (24),
    .AutoIncDefault(1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    ._CS       (cs_n),
    .RXValid   (rx_valid),
    .RXData    (rx_data),
    .AddressBus(address_bus),
    .WriteBus  (write_bus),
    ._Write    (write_n),
    .FrameError(frame_error),
    .Busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle RXValid pulse
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [7:0] addr, input logic [7:0] data);
    check({tag, "_wr"}, 32'(write_n), 32'd0);
    check({tag, "_addr"}, 32'(address_bus), 32'(addr));
    check({tag, "_data"}, 32'(write_bus), 32'(data));
    $display("write %s: addr=%0d data=%02h", tag, address_bus, write_bus);
  endtask

  initial begin
    rst      = 1'b1;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    check("rst_addr", 32'(address_bus), 32'h00);
    check("rst_data", 32'(write_bus), 32'h00);
    check("rst_wr", 32'(write_n), 32'd1);
    check("rst_err", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Frame 1: address 6, data AA then BB with a gap between them
    cs_n = 1'b0;
    tick();
    check("f1_busy", 32'(busy), 32'd1);
    send_byte(8'h06);
    check("f1_addr_nowr", 32'(write_n), 32'd1);
    send_byte(8'hAA);
    check_write("f1_w0", 8'd6, 8'hAA);
    tick();
    check("f1_pulse_end", 32'(write_n), 32'd1);
    check("f1_hold_addr", 32'(address_bus), 32'd6);
    check("f1_hold_data", 32'(write_bus), 32'hAA);
    send_byte(8'hBB);
    check_write("f1_w1", 8'd7, 8'hBB);
    cs_n = 1'b1;
    tick();
    check("f1_end_wr", 32'(write_n), 32'd1);
    check("f1_err", 32'(frame_error), 32'd0);
    check("f1_end_busy", 32'(busy), 32'd0);

    // Frame 2: address 23, back-to-back data shows wrap to 0
    cs_n = 1'b0;
    tick();
    send_byte(8'h17);
    send_byte(8'h11);
    check_write("f2_w0", 8'd23, 8'h11);
    send_byte(8'h22);
    check_write("f2_w1", 8'd0, 8'h22);
    cs_n = 1'b1;
    tick();
    check("f2_end_wr", 32'(write_n), 32'd1);

    // Frame 3: address 0x85 disables auto-increment
    cs_n = 1'b0;
    tick();
    send_byte(8'h85);
    send_byte(8'h01);
    check_write("f3_w0", 8'd5, 8'h01);
    send_byte(8'h02);
    check_write("f3_w1", 8'd5, 8'h02);
    send_byte(8'h03);
    check_write("f3_w2", 8'd5, 8'h03);
    cs_n = 1'b1;
    tick();

    // Frame 4: out-of-range address 0x30 discards the frame
    cs_n = 1'b0;
    tick();
    send_byte(8'h30);
    check("f4_err_set", 32'(frame_error), 32'd1);
    send_byte(8'h55);
    check("f4_no_wr0", 32'(write_n), 32'd1);
    tick();
    check("f4_no_wr1", 32'(write_n), 32'd1);
    check("f4_busy", 32'(busy), 32'd1);
    cs_n = 1'b1;
    tick();
    check("f4_err_sticky", 32'(frame_error), 32'd1);
    check("f4_end_busy", 32'(busy), 32'd0);
    $display("frame 4: discarded, FrameError=%0d", frame_error);

    // Frame 5: new frame clears the error; last byte arrives with _CS rising
    cs_n = 1'b0;
    tick();
    check("f5_err_clr", 32'(frame_error), 32'd0);
    send_byte(8'h02);
    rx_valid = 1'b1;
    rx_data  = 8'h9C;
    cs_n     = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_write("f5_last", 8'd2, 8'h9C);
    check("f5_busy", 32'(busy), 32'd0);
    tick();
    check("f5_pulse_end", 32'(write_n), 32'd1);

    // Frame 6: reset one cycle after a data byte aborts the frame
    cs_n = 1'b0;
    tick();
    send_byte(8'h00);
    send_byte(8'h77);
    rst = 1'b1;
    tick();
    check("f6_rst_wr", 32'(write_n), 32'd1);
    check("f6_rst_addr", 32'(address_bus), 32'h00);
    check("f6_rst_data", 32'(write_bus), 32'h00);
    check("f6_rst_err", 32'(frame_error), 32'd0);
    check("f6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("f6_post_wr", 32'(write_n), 32'd1);
    check("f6_post_busy", 32'(busy), 32'd1);
    // _CS was held low across reset: next byte is an address again
    send_byte(8'h04);
    check("f6_addr_nowr", 32'(write_n), 32'd1);
    send_byte(8'h66);
    check_write("f6_w0", 8'd4, 8'h66);
    cs_n = 1'b1;
    tick();
    check("f6_end_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spi_frame_decoder
